// File: rtl/adder78_ctrl_pkg.sv
// Shared types and helpers for the adder78 sharing controller.
package adder78_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int unsigned WIDTH = 78;

  typedef logic [WIDTH-1:0] word_t;

  function automatic logic parity(input word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/duplicated_carry_select_adder_78.sv
// 78-bit carry-select adder with a duplicated, inverted-rail sum and
// carry-based parity prediction for concurrent error detection.
module duplicated_carry_select_adder_78 (
  input  logic [77:0] a,
  input  logic [77:0] b,
  input  logic        pa,
  input  logic        pb,
  output logic [77:0] s,
  output logic [77:0] s_invert,
  output logic        papb,
  output logic        pab
);

  localparam int unsigned BLK  = 13;
  localparam int unsigned NBLK = 6;

  function automatic logic [77:0] cs_add(input logic [77:0] x, input logic [77:0] y);
    logic [77:0]  r;
    logic         c;
    logic [BLK:0] s0;
    logic [BLK:0] s1;
    r = '0;
    c = 1'b0;
    for (int unsigned i = 0; i < NBLK; i++) begin
      s0 = {1'b0, x[i*BLK +: BLK]} + {1'b0, y[i*BLK +: BLK]};
      s1 = {1'b0, x[i*BLK +: BLK]} + {1'b0, y[i*BLK +: BLK]} + (BLK+1)'(1);
      r[i*BLK +: BLK] = c ? s1[BLK-1:0] : s0[BLK-1:0];
      c = c ? s1[BLK] : s0[BLK];
    end
    return r;
  endfunction

  logic [77:0] s_dup;
  logic [77:0] c_vec;

  assign s        = cs_add(a, b);
  assign s_dup    = cs_add(a, b);
  assign s_invert = ~s_dup;
  // Carries recovered from the duplicate rail predict the parity of the primary sum.
  assign c_vec    = a ^ b ^ s_dup;
  assign papb     = pa ^ pb ^ (^c_vec);
  assign pab      = ^s;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from pointer, with wrap.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  always_comb begin
    int unsigned c;
    logic        found;
    grant = '0;
    index = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(pointer) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        grant[c] = 1'b1;
        index    = IW'(c);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder78_share_ctrl.sv
// Round-robin sequencer sharing one checked 78-bit adder between requesters.
// Optional ADDER78_FAULT_INJ_EN adds a fault_inj port that flips sum bit 0 in EXEC.
module adder78_share_ctrl #(
  parameter int unsigned WIDTH     = adder78_ctrl_pkg::WIDTH,
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned ERRW      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_err,
  output logic [2:0]                 rsp_retries,
  output logic [ERRW-1:0]            fault_cnt,
  output logic                       busy
`ifdef ADDER78_FAULT_INJ_EN
  ,
  input  logic                       fault_inj
`endif
);

  import adder78_ctrl_pkg::*;

  localparam int unsigned IW = $clog2(N_REQ);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     grant_idx;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              pa_q;
  logic              pb_q;
  logic [77:0]       s;
  logic [77:0]       s_invert;
  logic              papb;
  logic              pab;
  logic [WIDTH-1:0]  s_chk;
  logic              ok;
  logic [ERRW-1:0]   fault_cnt_inc;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (grant),
    .index   (grant_idx)
  );

  duplicated_carry_select_adder_78 u_add (
    .a        (a_q),
    .b        (b_q),
    .pa       (pa_q),
    .pb       (pb_q),
    .s        (s),
    .s_invert (s_invert),
    .papb     (papb),
    .pab      (pab)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign win_a     = req_a[WIDTH*32'(grant_idx) +: WIDTH];
  assign win_b     = req_b[WIDTH*32'(grant_idx) +: WIDTH];

`ifdef ADDER78_FAULT_INJ_EN
  assign s_chk = s ^ {{(WIDTH-1){1'b0}}, fault_inj};
`else
  assign s_chk = s;
`endif

  assign ok            = (s_chk == ~s_invert) && (papb == pab);
  assign fault_cnt_inc = (fault_cnt == '1) ? fault_cnt : fault_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pa_q        <= 1'b0;
      pb_q        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rsp_err     <= 1'b0;
      rsp_retries <= '0;
      fault_cnt   <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            a_q         <= win_a;
            b_q         <= win_b;
            pa_q        <= parity(word_t'(win_a));
            pb_q        <= parity(word_t'(win_b));
            rsp_id      <= grant_idx;
            ptr         <= (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            rsp_retries <= '0;
            busy        <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum <= s_chk;
          if (ok) begin
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (rsp_retries < 3'(MAX_RETRY)) begin
            rsp_retries <= rsp_retries + 1'b1;
            fault_cnt   <= fault_cnt_inc;
          end else begin
            fault_cnt <= fault_cnt_inc;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
